cpu_muldiv: RTL

//  Parametrised iterative multiply/divide unit beside cpu_execute; owns MUL_L, DIV_L, UDIV_L, MOD_L, UMOD_L.

---
 rtl/cpu_muldiv_pkg.sv | 33 +++
 rtl/cpu_muldiv_step.sv | 29 ++
 rtl/cpu_muldiv.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and small opcode-classification helpers.
package cpu_muldiv_pkg;

   localparam logic [2:0] MD_OP_MUL  = 3'd0;
   localparam logic [2:0] MD_OP_DIV  = 3'd1;
   localparam logic [2:0] MD_OP_UDIV = 3'd2;
   localparam logic [2:0] MD_OP_MOD  = 3'd3;
   localparam logic [2:0] MD_OP_UMOD = 3'd4;

   localparam int MD_ST_W = 3;

   typedef enum logic [MD_ST_W-1:0] {
      MD_ST_IDLE  = 3'd0,
      MD_ST_PREP  = 3'd1,
      MD_ST_RUN   = 3'd2,
      MD_ST_FIXUP = 3'd3,
      MD_ST_DONE  = 3'd4
   } md_state_e;

   function automatic logic md_op_valid(input logic [2:0] op);
      return op <= MD_OP_UMOD;
   endfunction

   function automatic logic md_op_signed(input logic [2:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_MOD);
   endfunction

   function automatic logic md_op_rem(input logic [2:0] op);
      return (op == MD_OP_MOD) || (op == MD_OP_UMOD);
   endfunction

endpackage

// File: rtl/cpu_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// Accumulator layout is {high half, low half}; multiply shifts right, divide shifts left.
module cpu_muldiv_step #(
   parameter int DATA_W = 32
) (
   input  logic                  i_mul,
   input  logic [2*DATA_W-1:0]   i_acc,
   input  logic [DATA_W-1:0]     i_operand,
   output logic [2*DATA_W-1:0]   o_acc
);

   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_rem_sh;
   logic [DATA_W:0] w_diff;

   always_comb begin
      w_sum    = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + (i_acc[0] ? {1'b0, i_operand} : '0);
      w_rem_sh = i_acc[2*DATA_W-1:DATA_W-1];
      w_diff   = w_rem_sh - {1'b0, i_operand};
      // remainder stays below the divisor, so a set MSB in the difference means borrow
      if (i_mul)
         o_acc = {w_sum, i_acc[DATA_W-1:1]};
      else if (!w_diff[DATA_W])
         o_acc = {w_diff[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
      else
         o_acc = {w_rem_sh[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b0};
   end

endmodule

// File: rtl/cpu_muldiv.sv
// Iterative multiply/divide unit beside the execute stage: accepts one op when idle,
// stalls the pipeline while working and returns one result with a write-enable pulse.
//   state | meaning
//   IDLE  | waiting for an accepted start
//   PREP  | take operand magnitudes, record signs, catch divide-by-zero
//   RUN   | DATA_W radix-2 iterations, counter DATA_W-1..0
//   FIXUP | apply result sign, select quotient/remainder/product
//   DONE  | one-cycle result pulse; a new start is accepted here
module cpu_muldiv
   import cpu_muldiv_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REGIDX_W = 4,
   parameter int MUL_FAST = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                flush_i,
   input  logic [2:0]          op_i,
   input  logic [DATA_W-1:0]   regA_i,
   input  logic [DATA_W-1:0]   regB_i,
   input  logic [REGIDX_W-1:0] register_write_index_i,
   output logic                busy_o,
   output logic                stall_o,
   output logic                done_o,
   output logic                register_we_o,
   output logic [REGIDX_W-1:0] register_write_index_o,
   output logic [DATA_W-1:0]   result_o,
   output logic                div0_o
);

   localparam int CNT_W = $clog2(DATA_W);

   md_state_e             r_state, w_next;
   logic [2:0]            r_op;
   logic [DATA_W-1:0]     r_a, r_b, r_opnd, r_result;
   logic [2*DATA_W-1:0]   r_acc, w_acc_step;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_neg_q, r_neg_r, r_div0;
   logic [REGIDX_W-1:0]   r_idx;

   logic                  w_accept, w_fast, w_b_zero, w_a_neg, w_b_neg;
   logic [DATA_W-1:0]     w_abs_a, w_abs_b, w_quot, w_rem, w_fix, w_fast_prod;

   assign w_accept    = start_i & ~flush_i & md_op_valid(op_i) &
                        ((r_state == MD_ST_IDLE) | (r_state == MD_ST_DONE));
   assign w_fast      = (MUL_FAST != 0) && (op_i == MD_OP_MUL);
   assign w_fast_prod = regA_i * regB_i;
   assign w_b_zero    = (r_b == '0);
   assign w_a_neg     = md_op_signed(r_op) & r_a[DATA_W-1];
   assign w_b_neg     = md_op_signed(r_op) & r_b[DATA_W-1];
   assign w_abs_a     = w_a_neg ? -r_a : r_a;
   assign w_abs_b     = w_b_neg ? -r_b : r_b;
   assign w_quot      = r_acc[DATA_W-1:0];
   assign w_rem       = r_acc[2*DATA_W-1:DATA_W];

   always_comb begin
      if (r_op == MD_OP_MUL)     w_fix = r_acc[DATA_W-1:0];
      else if (md_op_rem(r_op))  w_fix = r_neg_r ? -w_rem : w_rem;
      else                       w_fix = r_neg_q ? -w_quot : w_quot;
   end

   cpu_muldiv_step #(.DATA_W(DATA_W)) u_step (
      .i_mul     (r_op == MD_OP_MUL),
      .i_acc     (r_acc),
      .i_operand (r_opnd),
      .o_acc     (w_acc_step)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) r_state <= MD_ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (flush_i) w_next = MD_ST_IDLE;
      else begin
         case (r_state)
            MD_ST_IDLE, MD_ST_DONE:
               if (w_accept) w_next = w_fast ? MD_ST_DONE : MD_ST_PREP;
               else          w_next = MD_ST_IDLE;
            MD_ST_PREP:  w_next = ((r_op != MD_OP_MUL) && w_b_zero) ? MD_ST_DONE : MD_ST_RUN;
            MD_ST_RUN:   if (r_cnt == '0) w_next = MD_ST_FIXUP;
            MD_ST_FIXUP: w_next = MD_ST_DONE;
            default:     w_next = MD_ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o        = (r_state != MD_ST_IDLE);
      stall_o       = w_accept | (r_state == MD_ST_PREP) | (r_state == MD_ST_RUN) |
                      (r_state == MD_ST_FIXUP);
      done_o        = (r_state == MD_ST_DONE);
      register_we_o = (r_state == MD_ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_op <= '0; r_a <= '0; r_b <= '0; r_opnd <= '0; r_acc <= '0; r_cnt <= '0;
         r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_div0 <= 1'b0; r_idx <= '0; r_result <= '0;
      end else begin
         case (r_state)
            MD_ST_IDLE, MD_ST_DONE:
               if (w_accept) begin
                  r_op  <= op_i;
                  r_a   <= regA_i;
                  r_b   <= regB_i;
                  r_idx <= register_write_index_i;
                  if (w_fast) begin
                     r_result <= w_fast_prod;
                     r_div0   <= 1'b0;
                  end
               end
            MD_ST_PREP: begin
               r_neg_q <= w_a_neg ^ w_b_neg;
               r_neg_r <= w_a_neg;
               r_cnt   <= CNT_W'(DATA_W-1);
               if (r_op == MD_OP_MUL) begin
                  r_opnd <= r_a;
                  r_acc  <= {{DATA_W{1'b0}}, r_b};
               end else begin
                  r_opnd <= w_abs_b;
                  r_acc  <= {{DATA_W{1'b0}}, w_abs_a};
               end
               // divide-by-zero skips iteration: remainder is the raw dividend
               if (w_next == MD_ST_DONE) begin
                  r_result <= md_op_rem(r_op) ? r_a : '1;
                  r_div0   <= 1'b1;
               end
            end
            MD_ST_RUN: begin
               r_acc <= w_acc_step;
               r_cnt <= r_cnt - 1'b1;
            end
            MD_ST_FIXUP:
               if (!flush_i) begin
                  r_result <= w_fix;
                  r_div0   <= 1'b0;
               end
            default: ;
         endcase
      end
   end

   assign register_write_index_o = r_idx;
   assign result_o               = r_result;
   assign div0_o                 = r_div0;

endmodule
